// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Optional per-requester beat counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int FW       = ID_W + 1 + DATA_W
) (
  input  logic                      i_wr_clk,
  input  logic                      i_wr_rstn,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_fifo_wr_en,
  output logic [FW-1:0]             o_fifo_wr_data,
  input  logic                      i_fifo_full,
  output logic                      o_busy,
  output logic [NUM_REQ*16-1:0]     o_beat_cnt
);

  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]   pick;
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic              cur_valid, cur_last, accept;
  logic [DATA_W-1:0] cur_data;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + 1 + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // valid_rot[j] is requester (rr_ptr+1+j) mod NUM_REQ, so the lowest set bit wins
  assign valid_dbl = {i_req_valid, i_req_valid};
  assign valid_rot = valid_dbl[({1'b0, rr_ptr_q} + 1'b1) +: NUM_REQ];

  always_comb begin
    pick = rr_ptr_q;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid_rot[j]) pick = wrap_idx(rr_ptr_q, j);
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        cur_valid = i_req_valid[i];
        cur_last  = i_req_last[i];
        cur_data  = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = (state_q == GRANT) && cur_valid && !i_fifo_full;

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // forced release at MAX_BURST leaves last untouched; the requester simply re-arbitrates
        if (accept) begin
          if (cur_last || burst_cnt_q == BC_W'(MAX_BURST - 1)) begin
            state_d     = IDLE;
            rr_ptr_d    = grant_q;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = '0;
    o_req_ready    = '0;
    o_busy         = 1'b0;
    if (state_q == GRANT) begin
      o_busy         = 1'b1;
      o_fifo_wr_en   = accept;
      o_fifo_wr_data = {grant_q, cur_last, cur_data};
      for (int i = 0; i < NUM_REQ; i++) begin
        o_req_ready[i] = (grant_q == ID_W'(i)) && !i_fifo_full;
      end
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [15:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (accept && grant_q == ID_W'(gi) && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
        if (!i_wr_rstn) cnt_q <= '0;
        else            cnt_q <= cnt_d;
      end
      assign o_beat_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`else
  assign o_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle-by-cycle vector table plus burst-limit and reset sequences.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  valid = '0;
  logic [3:0]  last = '0;
  logic [31:0] data = '0;
  logic        full = 1'b0;
  logic [3:0]  rdy;
  logic        wr_en;
  logic [10:0] wd;
  logic        busy;
  logic [63:0] cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(16)) dut (
    .i_wr_clk(clk), .i_wr_rstn(rstn), .i_req_valid(valid), .i_req_last(last),
    .i_req_data(data), .o_req_ready(rdy), .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wd),
    .i_fifo_full(full), .o_busy(busy), .o_beat_cnt(cnt)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        en;
    logic [10:0] wd;
    logic [3:0]  rdy;
    logic        busy;
    bit          chk_cnt;
    logic [63:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] v, logic [3:0] l, logic [31:0] d, logic f,
                              logic en, logic [10:0] w, logic [3:0] r, logic b);
    vec_t x;
    x.rst = rst; x.v = v; x.l = l; x.d = d; x.f = f;
    x.en = en; x.wd = w; x.rdy = r; x.busy = b; x.chk_cnt = 1'b0; x.cnt = '0;
    return x;
  endfunction

  function automatic logic [63:0] cnt4(int a, int b, int c, int d);
`ifdef FIFO_WR_ARB_STATS_EN
    return {16'(d), 16'(c), 16'(b), 16'(a)};
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; valid = '0; last = '0; data = '0; full = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  logic [10:0] wlog[$];
  logic [10:0] exp_w;
  int  b1;
  bit  done2;

  initial begin
    // outputs while reset is held
    #12;
    chk("rst_en", 64'(wr_en), 64'd0);
    chk("rst_rdy", 64'(rdy), 64'd0);
    chk("rst_wd", 64'(wd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", cnt, 64'd0);

    // req0 3-beat packet: one bubble, then three back-to-back writes
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 32'h11, 0, 0, 11'h000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'h11, 0, 1, 11'h011, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 32'h22, 0, 1, 11'h022, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 32'h33, 0, 1, 11'h133, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h00, 0, 0, 11'h000, 4'b0000, 0));
    tbl[tbl.size()-1].chk_cnt = 1'b1;
    tbl[tbl.size()-1].cnt = cnt4(3, 0, 0, 0);

    // all four requesters with single-beat packets: grants rotate 0,1,2,3,0,1,2,3
    for (int k = 0; k < 16; k++) begin
      int g;
      g = (k / 2) % 4;
      if (k % 2 == 0)
        tbl.push_back(mk(k == 0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 0, 11'h000, 4'b0000, 0));
      else
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'hA3A2A1A0, 0, 1,
                         {2'(g), 1'b1, 8'hA0 + 8'(g)}, 4'(1 << g), 1));
    end
    tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0, 0, 0, 11'h000, 4'b0000, 0));
    tbl[tbl.size()-1].chk_cnt = 1'b1;
    tbl[tbl.size()-1].cnt = cnt4(2, 2, 2, 2);

    // req2 5-beat packet with full high for 4 cycles and one valid-low gap
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 32'h0050_0000, 0, 0, 11'h000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0050_0000, 0, 1, 11'h450, 4'b0100, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0051_0000, 0, 1, 11'h451, 4'b0100, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0052_0000, 1, 0, 11'h452, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0052_0000, 0, 1, 11'h452, 4'b0100, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h0053_0000, 0, 1, 11'h453, 4'b0100, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0053_0000, 0, 0, 11'h453, 4'b0100, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h0054_0000, 0, 1, 11'h554, 4'b0100, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 0, 0, 11'h000, 4'b0000, 0));
    tbl[tbl.size()-1].chk_cnt = 1'b1;
    tbl[tbl.size()-1].cnt = cnt4(0, 0, 5, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      @(posedge clk); #1;
      valid = tbl[i].v; last = tbl[i].l; data = tbl[i].d; full = tbl[i].f;
      @(negedge clk);
      chk($sformatf("row%0d_en", i), 64'(wr_en), 64'(tbl[i].en));
      chk($sformatf("row%0d_wd", i), 64'(wd), 64'(tbl[i].wd));
      chk($sformatf("row%0d_rdy", i), 64'(rdy), 64'(tbl[i].rdy));
      chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      if (tbl[i].chk_cnt) chk($sformatf("row%0d_cnt", i), cnt, tbl[i].cnt);
    end

    // req1 streams 20 beats without last while req2 waits: 16, then req2, then 4
    do_reset();
    b1 = 0; done2 = 1'b0;
    for (int c = 0; c < 100 && !(b1 == 20 && done2); c++) begin
      @(posedge clk); #1;
      valid = {1'b0, !done2, (b1 < 20), 1'b0};
      last  = 4'b0100;
      data  = {8'h00, 8'hEE, 8'(b1), 8'h00};
      full  = 1'b0;
      @(negedge clk);
      if (wr_en) begin
        wlog.push_back(wd);
        if (rdy[1]) b1++;
        if (rdy[2]) done2 = 1'b1;
      end
    end
    chk("s4_done", 64'(b1 == 20 && done2), 64'd1);
    chk("s4_writes", 64'(wlog.size()), 64'd21);
    for (int k = 0; k < 21 && k < wlog.size(); k++) begin
      if (k < 16)       exp_w = {2'd1, 1'b0, 8'(k)};
      else if (k == 16) exp_w = {2'd2, 1'b1, 8'hEE};
      else              exp_w = {2'd1, 1'b0, 8'(k - 1)};
      chk($sformatf("s4_beat%0d", k), 64'(wlog[k]), 64'(exp_w));
    end

    // async reset in the middle of a req3 packet, then req0 wins the first arbitration
    do_reset();
    @(posedge clk); #1;
    valid = 4'b1000; last = 4'b0000; data = 32'h3100_0000;
    @(negedge clk);
    chk("s5_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s5_beat1_wd", 64'(wd), 64'h631);
    @(posedge clk); #1;
    data = 32'h3200_0000;
    @(negedge clk);
    chk("s5_beat2_en", 64'(wr_en), 64'd1);
    #1 rstn = 1'b0;
    #1;
    chk("s5_rst_en", 64'(wr_en), 64'd0);
    chk("s5_rst_rdy", 64'(rdy), 64'd0);
    chk("s5_rst_wd", 64'(wd), 64'd0);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    chk("s5_rst_cnt", cnt, 64'd0);
    @(posedge clk); #1;
    valid = 4'b1001; data = 32'h3200_000A; rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("s5_regrant_rdy", 64'(rdy), 64'b0001);
    chk("s5_regrant_wd", 64'(wd), 64'h00A);
    chk("s5_regrant_en", 64'(wr_en), 64'd1);

    valid = '0; last = '0; data = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
